// File: rtl/axi4_fb_rd_slave.sv
// AXI4 read-only frame-buffer responder: one AR burst at a time, registered R beats, host byte-write preload port.
// Optional WRAP burst support is compiled in with `define VGA_FBRD_WRAP_EN.
module axi4_fb_rd_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [ID_WIDTH-1:0]          arid_i,
    input  logic [ADDR_WIDTH-1:0]        araddr_i,
    input  logic [7:0]                   arlen_i,
    input  logic [2:0]                   arsize_i,
    input  logic [1:0]                   arburst_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [ID_WIDTH-1:0]          rid_o,
    output logic [63:0]                  rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rlast_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    input  logic                         wr_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
    input  logic [63:0]                  wr_data_i,
    input  logic [7:0]                   wr_strb_i,
    output logic                         busy_o
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH) << 3;

    logic [63:0] fb_mem [MEM_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_all_q, err_all_d;
    logic [8:0]            issued_q, issued_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rlast_q, rlast_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [63:0]           rdata_q, rdata_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;

    logic                  idle, ar_fire, ar_err, beat_err, beat_load;
    logic [ADDR_WIDTH-1:0] beat_addr, next_addr;
    logic [7:0]            beat_len;
    logic [1:0]            beat_burst;
    logic [8:0]            beat_num;
    logic [IDX_W-1:0]      beat_idx;
    logic                  unused_addr_lsbs;

    assign idle             = (state_q == ST_IDLE);
    assign ar_fire          = idle && arvalid_i;
    assign unused_addr_lsbs = ^araddr_i[2:0];

    always_comb begin : p_ar_err
        ar_err = (arsize_i != 3'd3) || (arburst_i == 2'd3);
`ifdef VGA_FBRD_WRAP_EN
        if ((arburst_i == 2'd2) &&
            !((arlen_i == 8'd1) || (arlen_i == 8'd3) || (arlen_i == 8'd7) || (arlen_i == 8'd15)))
            ar_err = 1'b1;
`else
        if (arburst_i == 2'd2)
            ar_err = 1'b1;
`endif
    end

`ifdef VGA_FBRD_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;
    // Legal wrap lengths make (len+1)*8-1 equal to {len, 3'b111}.
    assign wrap_mask = {{(ADDR_WIDTH-11){1'b0}}, beat_len, 3'b111};
`endif

    // While idle, beat 0 comes straight from the AR channel so rvalid rises the cycle after the handshake.
    always_comb begin : p_beat
        beat_addr  = idle ? {araddr_i[ADDR_WIDTH-1:3], 3'b000} : addr_q;
        beat_len   = idle ? arlen_i : len_q;
        beat_burst = idle ? arburst_i : burst_q;
        beat_num   = idle ? 9'd0 : issued_q;
        beat_idx   = beat_addr[IDX_W+2:3];
        beat_err   = (idle ? ar_err : err_all_q) || ({1'b0, beat_addr} >= MEM_BYTES);
        beat_load  = idle ? ar_fire
                          : ((issued_q <= {1'b0, len_q}) && (!rvalid_q || rready_i));
        case (beat_burst)
            2'd0:    next_addr = beat_addr;
`ifdef VGA_FBRD_WRAP_EN
            2'd2:    next_addr = (beat_addr & ~wrap_mask) | ((beat_addr + ADDR_WIDTH'(8)) & wrap_mask);
`endif
            default: next_addr = beat_addr + ADDR_WIDTH'(8);
        endcase
    end

    always_comb begin : p_next
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        err_all_d = err_all_q;
        issued_d  = issued_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rid_d     = rid_q;
        if (ar_fire) begin
            state_d   = ST_BURST;
            id_d      = arid_i;
            len_d     = arlen_i;
            burst_d   = arburst_i;
            err_all_d = ar_err;
        end
        if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            if (rlast_q)
                state_d = ST_IDLE;
        end
        if (beat_load) begin
            rvalid_d = 1'b1;
            rlast_d  = (beat_num == {1'b0, beat_len});
            rresp_d  = beat_err ? 2'b10 : 2'b00;
            rdata_d  = beat_err ? 64'd0 : fb_mem[beat_idx];
            rid_d    = idle ? arid_i : id_q;
            addr_d   = next_addr;
            issued_d = beat_num + 9'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin : p_regs
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            err_all_q <= 1'b0;
            issued_q  <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            rid_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            err_all_q <= err_all_d;
            issued_q  <= issued_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rid_q     <= rid_d;
        end
    end

    // A read load in the same cycle as a host write sees the old word.
    always_ff @(posedge clk_i) begin : p_mem_wr
        if (wr_en_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_strb_i[b])
                    fb_mem[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
        end
    end

    assign arready_o = idle;
    assign busy_o    = !idle;
    assign rvalid_o  = rvalid_q;
    assign rlast_o   = rlast_q;
    assign rresp_o   = rresp_q;
    assign rdata_o   = rdata_q;
    assign rid_o     = rid_q;
endmodule

// File: tb/tb_axi4_fb_rd_slave.sv
// Bench for axi4_fb_rd_slave: directed vector table, hand-written corner sequences, random bursts vs a reference model.
`timescale 1ns/1ps
module tb_axi4_fb_rd_slave;
    localparam int AW    = 32;
    localparam int IW    = 4;
    localparam int DEPTH = 1024;
    localparam int IDXW  = $clog2(DEPTH);
    localparam int NVEC  = 8;
`ifdef VGA_FBRD_WRAP_EN
    localparam bit WRAP_ON = 1'b1;
`else
    localparam bit WRAP_ON = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_n_i = 1'b0;
    logic [IW-1:0]   arid_i = '0;
    logic [AW-1:0]   araddr_i = '0;
    logic [7:0]      arlen_i = '0;
    logic [2:0]      arsize_i = '0;
    logic [1:0]      arburst_i = '0;
    logic            arvalid_i = 1'b0;
    logic            arready_o;
    logic [IW-1:0]   rid_o;
    logic [63:0]     rdata_o;
    logic [1:0]      rresp_o;
    logic            rlast_o;
    logic            rvalid_o;
    logic            rready_i = 1'b0;
    logic            wr_en_i = 1'b0;
    logic [IDXW-1:0] wr_addr_i = '0;
    logic [63:0]     wr_data_i = '0;
    logic [7:0]      wr_strb_i = '0;
    logic            busy_o;

    always #5 clk_i = ~clk_i;

    axi4_fb_rd_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
        .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
        .rvalid_o(rvalid_o), .rready_i(rready_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [IW-1:0]     id;
        logic [AW-1:0]     addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic [1:0]        rr;
        logic [7:0][63:0]  data;
        logic [7:0][1:0]   resp;
    } vec_t;

    vec_t        vecs [NVEC];
    vec_t        v;
    int          total = 0;
    int          bad = 0;
    int          cyc;
    logic [63:0] model_mem [DEPTH];
    logic [63:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [IW-1:0] got_id[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_resp[$];
    logic        exp_last[$];
    logic [IW-1:0] exp_id[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic host_write(input logic [IDXW-1:0] a, input logic [63:0] d, input logic [7:0] s);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d; wr_strb_i = s;
        @(posedge clk_i); #1;
        wr_en_i = 1'b0;
        for (int b = 0; b < 8; b++)
            if (s[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    // Reference: address sequence from burst rules with plain arithmetic.
    task automatic model_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst);
        longint base, blk, start, a;
        bit err_all, legal_wrap, oob;
        exp_data.delete(); exp_resp.delete(); exp_last.delete(); exp_id.delete();
        legal_wrap = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        err_all = (size != 3'd3) || (burst == 2'd3) || ((burst == 2'd2) && !(WRAP_ON && legal_wrap));
        base  = longint'(addr) - longint'(addr % 8);
        blk   = (longint'(len) + 1) * 8;
        start = (base / blk) * blk;
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'd0)      a = base;
            else if (burst == 2'd2) a = start + ((base - start) + 8 * i) % blk;
            else                    a = (base + 8 * i) % 64'h1_0000_0000;
            oob = (a >= DEPTH * 8);
            if (err_all || oob) begin
                exp_data.push_back(64'd0); exp_resp.push_back(2'b10);
            end else begin
                exp_data.push_back(model_mem[int'(a / 8)]); exp_resp.push_back(2'b00);
            end
            exp_last.push_back(i == int'(len));
            exp_id.push_back(id);
        end
    endtask

    // rr: 0 = rready always high, 1 = toggling, 2 = random.
    task automatic do_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] rr);
        int beats, n;
        logic stalled;
        logic [63:0] pd;
        logic [1:0] pr;
        logic pl;
        logic [IW-1:0] pid;
        got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
        arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
        arvalid_i = 1'b1; rready_i = 1'b0;
        n = 0;
        while (!arready_o && n < 100) begin @(posedge clk_i); #1; n++; end
        check("ar_ready_wait", 64'(arready_o), 64'd1);
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        check("first_rvalid_latency", 64'(rvalid_o), 64'd1);
        check("busy_in_burst", 64'(busy_o), 64'd1);
        check("arready_in_burst", 64'(arready_o), 64'd0);
        beats = 0; n = 0; stalled = 1'b0;
        pd = '0; pr = '0; pl = 1'b0; pid = '0;
        while (beats <= int'(len) && n < 4000) begin
            case (rr)
                2'd0:    rready_i = 1'b1;
                2'd1:    rready_i = (n % 2 == 0);
                default: rready_i = 1'($urandom_range(0, 1));
            endcase
            if (stalled) begin
                check("stall_rvalid", 64'(rvalid_o), 64'd1);
                check("stall_rdata", rdata_o, pd);
                check("stall_meta", {57'd0, rresp_o, rlast_o, rid_o}, {57'd0, pr, pl, pid});
            end
            if (rvalid_o && rready_i) begin
                got_data.push_back(rdata_o); got_resp.push_back(rresp_o);
                got_last.push_back(rlast_o); got_id.push_back(rid_o);
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = rvalid_o;
                pd = rdata_o; pr = rresp_o; pl = rlast_o; pid = rid_o;
            end
            @(posedge clk_i); #1;
            n++;
        end
        rready_i = 1'b0;
        check("beat_count", 64'(beats), 64'(int'(len) + 1));
        check("post_rvalid", 64'(rvalid_o), 64'd0);
        check("post_arready", 64'(arready_o), 64'd1);
        check("post_busy", 64'(busy_o), 64'd0);
        $display("burst id=%0d addr=%h len=%0d size=%0d type=%0d rr=%0d beats=%0d cycles=%0d",
                 id, addr, len, size, burst, rr, beats, n);
    endtask

    task automatic compare_beats(input string tag);
        check({tag, " nbeats"}, 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            check($sformatf("%s b%0d data", tag, i), got_data[i], exp_data[i]);
            check($sformatf("%s b%0d resp", tag, i), 64'(got_resp[i]), 64'(exp_resp[i]));
            check($sformatf("%s b%0d last", tag, i), 64'(got_last[i]), 64'(exp_last[i]));
            check($sformatf("%s b%0d id", tag, i), 64'(got_id[i]), 64'(exp_id[i]));
        end
    endtask

    task automatic set_hdr(input int k, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] rr);
        vecs[k] = '0;
        vecs[k].id = id; vecs[k].addr = addr; vecs[k].len = len;
        vecs[k].size = size; vecs[k].burst = burst; vecs[k].rr = rr;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [IW-1:0] rid;
        logic [AW-1:0] raddr;
        logic [7:0]    rlen;
        logic [2:0]    rsize;
        logic [1:0]    rburst;
        int            k;

        // Directed vector table with hand-derived expectations.
        set_hdr(0, 4'd3, 32'h0, 8'd7, 3'd3, 2'd1, 2'd0);
        for (int i = 0; i < 8; i++) vecs[0].data[i] = 64'hA0 + 64'(i);
        set_hdr(1, 4'd3, 32'h0, 8'd7, 3'd3, 2'd1, 2'd1);
        for (int i = 0; i < 8; i++) vecs[1].data[i] = 64'hA0 + 64'(i);
        set_hdr(2, 4'd5, 32'h18, 8'd3, 3'd3, 2'd0, 2'd0);
        for (int i = 0; i < 4; i++) vecs[2].data[i] = 64'hA3;
        set_hdr(3, 4'd1, 32'((DEPTH - 2) * 8), 8'd3, 3'd3, 2'd1, 2'd0);
        vecs[3].data[0] = 64'hB000 + 64'(DEPTH - 2);
        vecs[3].data[1] = 64'hB000 + 64'(DEPTH - 1);
        vecs[3].resp[2] = 2'b10; vecs[3].resp[3] = 2'b10;
        set_hdr(4, 4'd2, 32'h0, 8'd3, 3'd2, 2'd1, 2'd2);
        for (int i = 0; i < 4; i++) vecs[4].resp[i] = 2'b10;
        set_hdr(5, 4'd6, 32'h30, 8'd3, 3'd3, 2'd2, 2'd0);
`ifdef VGA_FBRD_WRAP_EN
        vecs[5].data[0] = 64'hA6; vecs[5].data[1] = 64'hA7;
        vecs[5].data[2] = 64'hA4; vecs[5].data[3] = 64'hA5;
`else
        for (int i = 0; i < 4; i++) vecs[5].resp[i] = 2'b10;
`endif
        set_hdr(6, 4'd9, 32'h0, 8'd1, 3'd3, 2'd3, 2'd2);
        vecs[6].resp[0] = 2'b10; vecs[6].resp[1] = 2'b10;
        set_hdr(7, 4'd15, 32'hF, 8'd0, 3'd3, 2'd1, 2'd2);
        vecs[7].data[0] = 64'hA1;

        // Reset values, while asserted and after release.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst arready", 64'(arready_o), 64'd1);
        check("rst rvalid", 64'(rvalid_o), 64'd0);
        check("rst outputs", {rdata_o}, 64'd0);
        check("rst meta", {56'd0, rresp_o, rlast_o, busy_o, rid_o}, 64'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("post-rst arready", 64'(arready_o), 64'd1);
        check("post-rst rvalid", 64'(rvalid_o), 64'd0);

        // Preload the whole frame buffer so the model knows every word.
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 16)              host_write(IDXW'(i), 64'hA0 + 64'(i), 8'hFF);
            else if (i >= DEPTH - 16) host_write(IDXW'(i), 64'hB000 + 64'(i), 8'hFF);
            else                     host_write(IDXW'(i), {$urandom, $urandom}, 8'hFF);
        end

        for (int j = 0; j < NVEC; j++) begin
            v = vecs[j];
            do_burst(v.id, v.addr, v.len, v.size, v.burst, v.rr);
            exp_data.delete(); exp_resp.delete(); exp_last.delete(); exp_id.delete();
            for (int i = 0; i <= int'(v.len); i++) begin
                exp_data.push_back(v.data[i]); exp_resp.push_back(v.resp[i]);
                exp_last.push_back(i == int'(v.len)); exp_id.push_back(v.id);
            end
            compare_beats($sformatf("vec%0d", j));
        end

        // Host write to word 1 in the same cycle beat 1 is loaded: beat returns the old word.
        arid_i = 4'd7; araddr_i = 32'h0; arlen_i = 8'd3; arsize_i = 3'd3; arburst_i = 2'd1;
        arvalid_i = 1'b1; rready_i = 1'b0;
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        check("wrseq beat0", rdata_o, 64'hA0);
        @(posedge clk_i); #1;
        check("wrseq hold", rdata_o, 64'hA0);
        rready_i = 1'b1;
        wr_en_i = 1'b1; wr_addr_i = IDXW'(1); wr_data_i = 64'hFFFF; wr_strb_i = 8'h03;
        @(posedge clk_i); #1;
        wr_en_i = 1'b0;
        model_mem[1][15:0] = 16'hFFFF;
        check("wrseq beat1 pre-write", rdata_o, 64'hA1);
        cyc = 0;
        while (!(rvalid_o && rlast_o) && cyc < 20) begin @(posedge clk_i); #1; cyc++; end
        check("wrseq last beat data", rdata_o, 64'hA3);
        @(posedge clk_i); #1;
        rready_i = 1'b0;
        check("wrseq idle rvalid", 64'(rvalid_o), 64'd0);
        $display("wrseq burst id=7 done");
        do_burst(4'd2, 32'h8, 8'd0, 3'd3, 2'd1, 2'd0);
        check("wrseq readback nbeats", 64'(got_data.size()), 64'd1);
        if (got_data.size() > 0)
            check("wrseq readback merged", got_data[0], 64'hFFFF);

        // Reset asserted mid-burst clears outputs without waiting for a clock edge.
        arid_i = 4'd4; araddr_i = 32'h0; arlen_i = 8'd7; arsize_i = 3'd3; arburst_i = 2'd1;
        arvalid_i = 1'b1; rready_i = 1'b0;
        @(posedge clk_i); #1;
        arvalid_i = 1'b0;
        check("midrst rvalid before", 64'(rvalid_o), 64'd1);
        @(posedge clk_i); #2;
        rst_n_i = 1'b0;
        #1;
        check("midrst rvalid", 64'(rvalid_o), 64'd0);
        check("midrst arready", 64'(arready_o), 64'd1);
        check("midrst rdata", rdata_o, 64'd0);
        check("midrst meta", {56'd0, rresp_o, rlast_o, busy_o, rid_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        $display("midrst sequence done");
        model_burst(4'd8, 32'h10, 8'd2, 3'd3, 2'd1);
        do_burst(4'd8, 32'h10, 8'd2, 3'd3, 2'd1, 2'd0);
        compare_beats("after_rst");

        // Random bursts against the reference model, with host writes between bursts.
        for (int t = 0; t < 40; t++) begin
            rburst = 2'($urandom_range(0, 3));
            if (rburst == 2'd2 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, 3);
                rlen = 8'((2 << k) - 1);
            end else begin
                rlen = 8'($urandom_range(0, 15));
            end
            rsize = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            raddr = 32'($urandom_range(0, DEPTH * 8 + 127));
            rid   = IW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                host_write(IDXW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            model_burst(rid, raddr, rlen, rsize, rburst);
            do_burst(rid, raddr, rlen, rsize, rburst, 2'd2);
            compare_beats($sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
